con_ff_unit: RTL

Registered, parametrised branch-condition unit for the CPU datapath. It evaluates the IR C2 field against the bus value and a latched carry/overflow condition-code register, then holds the result in a CON flip-flop. The result is offered to the control unit through a valid/ack handshake. It also keeps saturating evaluation and taken counters for performance monitoring, and sits between the bus/ALU and the control sequencer.

---
 rtl/con_pkg.sv | 21 ++
 rtl/con_decode.sv | 39 +++
 rtl/con_ff_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/con_pkg.sv
// Shared definitions for the CON flip-flop unit: condition codes, c2 invert bit
// and the handshake FSM state encoding.
package con_pkg;

    localparam logic [2:0] COND_ZERO    = 3'b000;
    localparam logic [2:0] COND_NONZERO = 3'b001;
    localparam logic [2:0] COND_POS     = 3'b010;
    localparam logic [2:0] COND_NEG     = 3'b011;
    localparam logic [2:0] COND_GTZ     = 3'b100;
    localparam logic [2:0] COND_LEZ     = 3'b101;
    localparam logic [2:0] COND_CARRY   = 3'b110;
    localparam logic [2:0] COND_OVF     = 3'b111;

    localparam int C2_INV_BIT = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } con_state_e;

endpackage

// File: rtl/con_decode.sv
// Combinational branch-condition decoder: selects a condition on the signed
// bus value or the latched condition codes, then applies the c2 invert bit.
module con_decode
    import con_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            c2,
    input  logic [DATA_WIDTH-1:0] bus,
    input  logic                  cc_carry,
    input  logic                  cc_ovf,
    output logic                  result
);

    logic is_zero;
    logic is_neg;
    logic raw;

    assign is_zero = (bus == '0);
    assign is_neg  = bus[DATA_WIDTH-1];

    always_comb begin
        raw = 1'b0;
        case (c2[2:0])
            COND_ZERO:    raw = is_zero;
            COND_NONZERO: raw = !is_zero;
            COND_POS:     raw = !is_neg;
            COND_NEG:     raw = is_neg;
            COND_GTZ:     raw = !is_neg && !is_zero;
            COND_LEZ:     raw = is_neg || is_zero;
            COND_CARRY:   raw = cc_carry;
            COND_OVF:     raw = cc_ovf;
            default:      raw = 1'b0;
        endcase
    end

    assign result = raw ^ c2[C2_INV_BIT];

endmodule

// File: rtl/con_ff_unit.sv
// Registered branch-condition unit: CON flip-flop with valid/ack handshake,
// condition-code register and saturating evaluation/taken counters.
module con_ff_unit
    import con_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [3:0]            c2,
    input  logic [DATA_WIDTH-1:0] bus,
    input  logic                  con_in,
    input  logic                  cc_in,
    input  logic                  alu_carry,
    input  logic                  alu_ovf,
    input  logic                  branch_ack,
    input  logic                  cnt_clr,
    output logic                  flag,
    output logic                  flag_valid,
    output logic                  cc_carry,
    output logic                  cc_ovf,
    output logic [CNT_WIDTH-1:0]  eval_count,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    con_state_e           state_q, state_d;
    logic                 flag_q, flag_d;
    logic                 cc_carry_q, cc_carry_d;
    logic                 cc_ovf_q, cc_ovf_d;
    logic [CNT_WIDTH-1:0] eval_count_q, eval_count_d;
    logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;
    logic                 result;

    // Decoder sees the registered cc values, so a same-cycle cc_in update is not visible yet
    con_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
        .c2       (c2),
        .bus      (bus),
        .cc_carry (cc_carry_q),
        .cc_ovf   (cc_ovf_q),
        .result   (result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (con_in) state_d = ST_VALID;
            ST_VALID: if (branch_ack && !con_in) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flag_d        = con_in ? result : flag_q;
        cc_carry_d    = cc_in ? alu_carry : cc_carry_q;
        cc_ovf_d      = cc_in ? alu_ovf : cc_ovf_q;
        eval_count_d  = eval_count_q;
        taken_count_d = taken_count_q;
        if (cnt_clr) begin
            eval_count_d  = '0;
            taken_count_d = '0;
        end else if (con_in) begin
            if (eval_count_q != CNT_MAX)
                eval_count_d = eval_count_q + 1'b1;
            if (result && taken_count_q != CNT_MAX)
                taken_count_d = taken_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= ST_IDLE;
            flag_q        <= 1'b0;
            cc_carry_q    <= 1'b0;
            cc_ovf_q      <= 1'b0;
            eval_count_q  <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flag_q        <= flag_d;
            cc_carry_q    <= cc_carry_d;
            cc_ovf_q      <= cc_ovf_d;
            eval_count_q  <= eval_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign flag        = flag_q;
    assign flag_valid  = (state_q == ST_VALID);
    assign cc_carry    = cc_carry_q;
    assign cc_ovf      = cc_ovf_q;
    assign eval_count  = eval_count_q;
    assign taken_count = taken_count_q;

endmodule
